mul_pipe: RTL and testbench
===========================

Name: mul_pipe

Overview:
- Parametrised, handshaked, pipelined radix-4 Booth / Wallace multiplier for the core's MUL/MULT/MULTU/MULH-class ops.
- Supports per-operand signedness: signed, unsigned and mixed signed × unsigned.
- Pipeline depth is configurable. A tag travels with each op.
- Supports valid/ready backpressure and a flush that kills in-flight ops on exceptions.

Parameters:
- XLEN, 32, operand width; must be even, ≥8.
- STAGES, 2, pipeline depth 1..3; sets latency.
- TAG_W, 4, width of the sideband tag carried alongside each op.

Ports:
- mul_clk  input  1  clock; all state updates on rising edge.
- mul_reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept this cycle.
- in_x  input  XLEN  multiplicand.
- in_y  input  XLEN  multiplier.
- in_x_signed  input  1  treat in_x as two's complement.
- in_y_signed  input  1  treat in_y as two's complement.
- in_tag  input  TAG_W  sideband; returned unchanged with the result.
- flush  input  1  discard all in-flight ops.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  2*XLEN  full product.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- One clock, mul_clk. mul_reset is synchronous and active-high.
- Arithmetic:
  - x_ext = in_x extended to 2*XLEN, sign-extended iff in_x_signed, else zero-extended.
  - y_ext = in_y extended by 2 bits (sign iff in_y_signed), with a 0 appended below the LSB.
  - XLEN/2+1 Booth partial products; each one's negation carry is injected into the Wallace tree / final adder.
  - Result is exactly x*y mod 2^(2*XLEN) under the selected signedness.
- Stage boundaries:
  - STAGES=1: fully combinational datapath feeding the output register.
  - STAGES=2: adds a register after partial-product generation.
  - STAGES=3: additionally registers the tree's carry/sum vectors before the final adder.
- Latency: an op accepted in cycle N shows out_valid in cycle N+STAGES when not stalled.
- Throughput: 1 op/cycle.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance & ~flush & ~mul_reset.
  - Accept occurs when in_valid & in_ready.
  - Each stage holds a valid bit plus data/tag. All stages shift together only when advance=1; otherwise every stage, including the output, holds.
  - Valid bubbles propagate normally; the pipeline does not collapse bubbles.
  - While out_valid=1 and out_ready=0, out_result and out_tag are stable.
  - A result is consumed when out_valid & out_ready. Combined with an accept in the same cycle, this is legal and required for full throughput.
- Flush:
  - In the flush cycle, all stage valid bits, including out_valid, clear at the next edge.
  - The op offered that cycle is not accepted.
  - A result presented that cycle counts as consumed only if out_ready=1; the consumer must ignore it otherwise.
  - Data registers need not clear.
- Reset:
  - Clears all valid bits, out_result to 0 and out_tag to 0.
  - in_ready is 0 during reset.
  - Reset mid-operation drops all ops; no partial result ever appears afterwards.
- Priority: mul_reset > flush > advance.
- Ordering: results leave strictly in accept order; no op is duplicated or lost except by flush or reset.

Test Plan:
1. XLEN=32, STAGES=2, unsigned: 0xFFFFFFFF × 0xFFFFFFFF -> out_result=0xFFFFFFFE_00000001, out_valid exactly 2 cycles after accept, tag echoed.
2. Signed:
   - -1 × -1 -> 0x00000000_00000001.
   - 0x80000000 × 0x80000000 -> 0x40000000_00000000.
   - 0x7FFFFFFF × 0x80000000 -> 0xC0000000_80000000.
3. Mixed: x signed 0xFFFFFFFF × y unsigned 0xFFFFFFFF -> 0xFFFFFFFF_00000001. Random 10k ops across all four signedness combos and STAGES=1,2,3 (and XLEN=16) are checked against a reference model.
4. Backpressure: 4 back-to-back ops with tags 0..3, out_ready held low 5 cycles -> in_ready drops once out_valid=1, output stable, then results drain in tag order 0,1,2,3 at 1/cycle with none lost.
5. Flush: 2 ops in flight at STAGES=3, flush pulsed with in_valid=1 -> next cycle out_valid=0; no flushed tag or the offered op ever appears; an op accepted the cycle after flush returns correctly STAGES cycles later.
6. mul_reset asserted for 1 cycle with a full pipeline while out_ready=0 -> out_valid=0, out_result=0, out_tag=0, in_ready=0 during reset; normal operation resumes the next cycle.

Source files
------------

// File: rtl/mul_pipe.sv
// Pipelined radix-4 Booth / Wallace-tree multiplier with valid/ready handshake,
// flush and a sideband tag. Produces the full 2*XLEN-bit product for any mix of
// signed/unsigned operands. Pipeline depth (1..3) is set by STAGES.
module mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic              mul_clk,
    input  logic              mul_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_x,
    input  logic [XLEN-1:0]   in_y,
    input  logic              in_x_signed,
    input  logic              in_y_signed,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*XLEN-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int W    = 2 * XLEN;     // product width
    localparam int NPP  = XLEN / 2 + 1; // Booth partial products
    localparam int NROW = NPP + 1;      // plus one row collecting the negation carries

    // Number of 3:2 compressor levels needed to bring NROW rows down to two.
    function automatic int tree_levels(input int rows);
        int n;
        int lv;
        n  = rows;
        lv = 0;
        while (n > 2) begin
            n  = (n / 3) * 2 + n % 3;
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int LEVELS = tree_levels(NROW);

    // Handshake
    logic                    advance;
    logic                    accept;

    // Output register
    logic                    out_valid_q;
    logic [W-1:0]            out_result_q;
    logic [TAG_W-1:0]        out_tag_q;

    // Partial-product generation
    logic [W-1:0]            x_ext;
    logic [XLEN+2:0]         y_ext;
    logic [2:0]              booth_grp;
    logic [W-1:0]            booth_mag;
    logic                    booth_neg;
    logic [W-1:0]            neg_row;
    logic [NROW-1:0][W-1:0]  pp_rows;

    // Wallace tree
    logic                    tree_valid;
    logic [TAG_W-1:0]        tree_tag;
    logic [NROW-1:0][W-1:0]  tree_in;
    logic [NROW-1:0][W-1:0]  csa_cur;
    logic [NROW-1:0][W-1:0]  csa_nxt;
    int                      csa_cnt;
    logic [W-1:0]            tree_sum;
    logic [W-1:0]            tree_carry;

    // Final adder
    logic                    add_valid;
    logic [TAG_W-1:0]        add_tag;
    logic [W-1:0]            add_sum;
    logic [W-1:0]            add_carry;
    logic [W-1:0]            product;

    // The whole pipe moves as one; a stalled output freezes every stage behind it.
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance & ~flush & ~mul_reset;
    assign accept   = in_valid & in_ready;

    // Radix-4 Booth recoding: each negative digit is built as ~mag with a +1 placed at
    // the digit's weight in neg_row, so no row needs its own incrementer.
    always_comb begin
        x_ext     = in_x_signed ? {{XLEN{in_x[XLEN-1]}}, in_x} : {{XLEN{1'b0}}, in_x};
        y_ext     = {{2{in_y_signed & in_y[XLEN-1]}}, in_y, 1'b0};
        booth_grp = 3'b000;
        booth_mag = '0;
        booth_neg = 1'b0;
        neg_row   = '0;
        pp_rows   = '0;
        for (int i = 0; i < NPP; i++) begin
            booth_grp = y_ext[2*i +: 3];
            case (booth_grp)
                3'b001, 3'b010: begin booth_mag = x_ext;        booth_neg = 1'b0; end
                3'b011:         begin booth_mag = x_ext << 1;   booth_neg = 1'b0; end
                3'b100:         begin booth_mag = x_ext << 1;   booth_neg = 1'b1; end
                3'b101, 3'b110: begin booth_mag = x_ext;        booth_neg = 1'b1; end
                default:        begin booth_mag = '0;           booth_neg = 1'b0; end
            endcase
            pp_rows[i]   = booth_neg ? ((~booth_mag) << (2 * i)) : (booth_mag << (2 * i));
            neg_row[2*i] = booth_neg;
        end
        pp_rows[NPP] = neg_row;
    end

    generate
        if (STAGES >= 2) begin : g_pp_reg
            logic                   s1_valid_q;
            logic [TAG_W-1:0]       s1_tag_q;
            logic [NROW-1:0][W-1:0] s1_rows_q;

            // Partial-product register; data only loads for real ops.
            always_ff @(posedge mul_clk) begin
                if (mul_reset || flush) begin
                    s1_valid_q <= 1'b0;
                end else if (advance) begin
                    s1_valid_q <= accept;
                    if (accept) begin
                        s1_tag_q  <= in_tag;
                        s1_rows_q <= pp_rows;
                    end
                end
            end

            // Tree consumes the registered partial products.
            always_comb begin
                tree_valid = s1_valid_q;
                tree_tag   = s1_tag_q;
                tree_in    = s1_rows_q;
            end
        end else begin : g_pp_comb
            // Tree consumes the partial products directly.
            always_comb begin
                tree_valid = accept;
                tree_tag   = in_tag;
                tree_in    = pp_rows;
            end
        end
    endgenerate

    // Wallace reduction: each level groups live rows in threes into sum/carry pairs,
    // leftovers pass through, until only sum and carry remain.
    always_comb begin
        csa_cnt = NROW;
        csa_cur = tree_in;
        csa_nxt = '0;
        for (int lv = 0; lv < LEVELS; lv++) begin
            csa_nxt = '0;
            for (int g = 0; g < NROW / 3; g++) begin
                if (g < csa_cnt / 3) begin
                    csa_nxt[2*g]   = csa_cur[3*g] ^ csa_cur[3*g+1] ^ csa_cur[3*g+2];
                    csa_nxt[2*g+1] = ((csa_cur[3*g]   & csa_cur[3*g+1]) |
                                      (csa_cur[3*g]   & csa_cur[3*g+2]) |
                                      (csa_cur[3*g+1] & csa_cur[3*g+2])) << 1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (k < csa_cnt % 3) begin
                    csa_nxt[2*(csa_cnt/3)+k] = csa_cur[3*(csa_cnt/3)+k];
                end
            end
            csa_cur = csa_nxt;
            csa_cnt = (csa_cnt / 3) * 2 + csa_cnt % 3;
        end
        tree_sum   = csa_cur[0];
        tree_carry = csa_cur[1];
    end

    generate
        if (STAGES == 3) begin : g_tree_reg
            logic             s2_valid_q;
            logic [TAG_W-1:0] s2_tag_q;
            logic [W-1:0]     s2_sum_q;
            logic [W-1:0]     s2_carry_q;

            // Carry-save register between the tree and the final adder.
            always_ff @(posedge mul_clk) begin
                if (mul_reset || flush) begin
                    s2_valid_q <= 1'b0;
                end else if (advance) begin
                    s2_valid_q <= tree_valid;
                    if (tree_valid) begin
                        s2_tag_q   <= tree_tag;
                        s2_sum_q   <= tree_sum;
                        s2_carry_q <= tree_carry;
                    end
                end
            end

            // Final adder reads the registered carry-save pair.
            always_comb begin
                add_valid = s2_valid_q;
                add_tag   = s2_tag_q;
                add_sum   = s2_sum_q;
                add_carry = s2_carry_q;
            end
        end else begin : g_tree_comb
            // Final adder reads the tree outputs directly.
            always_comb begin
                add_valid = tree_valid;
                add_tag   = tree_tag;
                add_sum   = tree_sum;
                add_carry = tree_carry;
            end
        end
    endgenerate

    assign product = add_sum + add_carry;

    // Output register: reset clears everything, flush only drops the valid bit.
    always_ff @(posedge mul_clk) begin
        if (mul_reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
        end else if (advance) begin
            out_valid_q <= add_valid;
            if (add_valid) begin
                out_result_q <= product;
                out_tag_q    <= add_tag;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: four instances (XLEN=32 with STAGES=1,2,3 and XLEN=16 with
// STAGES=2) share one stimulus stream. Each instance has a queue-based scoreboard
// fed by an arithmetic product model; directed sequences exercise latency,
// backpressure, flush and reset with literal expectations.
module tb_mul_pipe;

    localparam int NCFG = 4;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] x;
    logic [31:0] y;
    logic        xs;
    logic        ys;
    logic [3:0]  tag;
    logic        flush;
    logic        out_ready;
    bit          end_check = 1'b0;

    logic        ir_w  [NCFG];
    logic        ov_w  [NCFG];
    logic [63:0] res_w [NCFG];
    logic [3:0]  tag_w [NCFG];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Reference product: operands extended to wide signed values, multiplied, truncated.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit as, input bit bs, input int xw);
        logic signed [127:0] av;
        logic signed [127:0] bv;
        logic signed [127:0] p;
        if (xw == 16) begin
            av = {{112{as & a[15]}}, a[15:0]};
            bv = {{112{bs & b[15]}}, b[15:0]};
        end else begin
            av = {{96{as & a[31]}}, a};
            bv = {{96{bs & b[31]}}, b};
        end
        p = av * bv;
        return (xw == 16) ? {32'h0, p[31:0]} : p[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_8000;
            5:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int XW = (gi == 3) ? 16 : 32;
        localparam int ST = (gi == 3) ? 2 : gi + 1;

        logic            ir;
        logic            ov;
        logic [2*XW-1:0] res;
        logic [3:0]      otag;
        exp_t            q[$];
        exp_t            e;
        bit              exp_ready;

        mul_pipe #(.XLEN(XW), .STAGES(ST), .TAG_W(4)) u_dut (
            .mul_clk     (clk),
            .mul_reset   (rst),
            .in_valid    (in_valid),
            .in_ready    (ir),
            .in_x        (x[XW-1:0]),
            .in_y        (y[XW-1:0]),
            .in_x_signed (xs),
            .in_y_signed (ys),
            .in_tag      (tag),
            .flush       (flush),
            .out_valid   (ov),
            .out_ready   (out_ready),
            .out_result  (res),
            .out_tag     (otag)
        );

        assign ir_w[gi]  = ir;
        assign ov_w[gi]  = ov;
        assign res_w[gi] = 64'(res);
        assign tag_w[gi] = otag;

        // Scoreboard: decide what happens at the coming edge and compare in accept order.
        always @(negedge clk) begin
            exp_ready = (!ov || out_ready) && !flush && !rst;
            check($sformatf("in_ready cfg%0d", gi), 64'(ir), 64'(exp_ready));
            if (!rst && ov) begin
                if (q.size() == 0) begin
                    check($sformatf("out_valid_without_op cfg%0d", gi), 64'(ov), 64'd0);
                end else if (out_ready) begin
                    e = q.pop_front();
                    check($sformatf("result cfg%0d", gi), 64'(res), e.res);
                    check($sformatf("tag cfg%0d", gi), 64'(otag), 64'(e.tag));
                end
            end
            if (rst || flush) begin
                q.delete();
            end else if (in_valid && exp_ready) begin
                e.res = ref_mul(x, y, xs, ys, XW);
                e.tag = tag;
                q.push_back(e);
            end
            if (end_check) begin
                check($sformatf("drained cfg%0d", gi), 64'(q.size()), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single isolated op with out_ready=1; checks per-depth latency and value on cfg0..2.
    task automatic directed_op(input logic [31:0] a, input logic [31:0] b, input bit as,
                               input bit bs, input logic [3:0] t, input logic [63:0] exp);
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        xs        = as;
        ys        = bs;
        tag       = t;
        out_ready = 1'b1;
        @(negedge clk);
        check("directed_accept", 64'(ir_w[1]), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            for (int gi = 0; gi < 3; gi++) begin
                check($sformatf("latency s%0d k%0d", gi + 1, k), 64'(ov_w[gi]), 64'(k == gi + 1));
                if (k == gi + 1) begin
                    check($sformatf("directed_result s%0d", gi + 1), res_w[gi], exp);
                    check($sformatf("directed_tag s%0d", gi + 1), 64'(tag_w[gi]), 64'(t));
                end
            end
            tick();
        end
    endtask

    initial begin
        int t;
        int got;
        int first_c;
        int last_c;

        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        xs        = 1'b0;
        ys        = 1'b0;
        tag       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int gi = 0; gi < NCFG; gi++) begin
            check($sformatf("reset_valid cfg%0d", gi), 64'(ov_w[gi]), 64'd0);
            check($sformatf("reset_result cfg%0d", gi), res_w[gi], 64'd0);
            check($sformatf("reset_tag cfg%0d", gi), 64'(tag_w[gi]), 64'd0);
        end
        tick();

        // Hand-computed values pinning the reference model
        check("model_uu32", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32), 64'hFFFF_FFFE_0000_0001);
        check("model_su16", ref_mul(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 16), 64'h0000_0000_FFFF_0001);
        check("model_ss32", ref_mul(32'h0000_3039, 32'hFFFF_FFFD, 1'b1, 1'b1, 32), 64'hFFFF_FFFF_FFFF_6F55);

        // Directed products with literal results
        directed_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd5, 64'hFFFF_FFFE_0000_0001);
        directed_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd6, 64'h0000_0000_0000_0001);
        directed_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd7, 64'h4000_0000_0000_0000);
        directed_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 4'd8, 64'hC000_0000_8000_0000);
        directed_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd9, 64'hFFFF_FFFF_0000_0001);

        // Backpressure on STAGES=2: four ops, out_ready low for the first 5 cycles
        t       = 0;
        got     = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 5);
            in_valid  = (t < 4);
            tag       = 4'(t);
            x         = 32'(t + 1);
            y         = 32'h10;
            xs        = 1'b0;
            ys        = 1'b0;
            @(negedge clk);
            if (ov_w[1] && !out_ready) begin
                check("stall_in_ready", 64'(ir_w[1]), 64'd0);
                check("stall_result", res_w[1], 64'h10);
                check("stall_tag", 64'(tag_w[1]), 64'd0);
            end
            if (ov_w[1] && out_ready) begin
                check("drain_tag", 64'(tag_w[1]), 64'(got));
                check("drain_result", res_w[1], 64'((got + 1) * 16));
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            if (in_valid && ir_w[1]) t++;
            tick();
        end
        in_valid = 1'b0;
        check("drain_count", 64'(got), 64'd4);
        check("drain_span", 64'(last_c - first_c), 64'd3);

        // Flush on STAGES=3 with two ops in flight and an op offered
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            tag      = 4'(8 + k);
            x        = 32'h1234_5678;
            y        = 32'(k + 3);
            tick();
        end
        flush    = 1'b1;
        tag      = 4'd10;
        @(negedge clk);
        check("flush_in_ready", 64'(ir_w[2]), 64'd0);
        tick();
        flush = 1'b0;
        tag   = 4'd11;
        x     = 32'h0000_3039;
        y     = 32'hFFFF_FFFD;
        xs    = 1'b1;
        ys    = 1'b1;
        @(negedge clk);
        check("post_flush_valid", 64'(ov_w[2]), 64'd0);
        check("post_flush_accept", 64'(ir_w[2]), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("flush_latency k%0d", k), 64'(ov_w[2]), 64'(k == 3));
            if (ov_w[2]) begin
                check("flush_follow_tag", 64'(tag_w[2]), 64'd11);
                check("flush_follow_result", res_w[2], 64'hFFFF_FFFF_FFFF_6F55);
            end
            tick();
        end

        // Reset with a full, stalled pipeline
        out_ready = 1'b0;
        xs        = 1'b0;
        ys        = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            tag      = 4'(k);
            x        = 32'(k * 7);
            y        = 32'hABCD;
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        for (int gi = 0; gi < NCFG; gi++) begin
            check($sformatf("in_ready_in_reset cfg%0d", gi), 64'(ir_w[gi]), 64'd0);
        end
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int gi = 0; gi < NCFG; gi++) begin
            check($sformatf("mid_reset_valid cfg%0d", gi), 64'(ov_w[gi]), 64'd0);
            check($sformatf("mid_reset_result cfg%0d", gi), res_w[gi], 64'd0);
            check($sformatf("mid_reset_tag cfg%0d", gi), 64'(tag_w[gi]), 64'd0);
        end
        check("resume_in_ready", 64'(ir_w[1]), 64'd1);
        tick();
        directed_op(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 4'd12, 64'd15);

        // Randomised traffic with backpressure and occasional flushes
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = pick();
            y         = pick();
            xs        = 1'($urandom_range(0, 1));
            ys        = 1'($urandom_range(0, 1));
            tag       = 4'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Drain and confirm nothing was lost
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        end_check = 1'b1;
        tick();
        end_check = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
